// File: rtl/i2c_pkg.sv
// Shared types and constants for the i2c_core transaction sequencer:
// FSM states, status codes, TX word layout and core status/irq bit indices.
package i2c_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_RLEN,
    S_RDATA,
    S_WAIT,
    S_DONE,
    S_ABORT
  } state_t;

  localparam logic [1:0] I2C_ERR_OK   = 2'd0;
  localparam logic [1:0] I2C_ERR_NACK = 2'd1;
  localparam logic [1:0] I2C_ERR_AL   = 2'd2;
  localparam logic [1:0] I2C_ERR_TMO  = 2'd3;

  localparam int TXW_START = 8;
  localparam int TXW_STOP  = 9;

  localparam int SR_TX_EMPTY = 7;
  localparam int SR_RX_EMPTY = 6;
  localparam int SR_TX_FULL  = 4;
  localparam int SR_BUS_BUSY = 2;

  localparam int IRQ_AL   = 0;
  localparam int IRQ_NACK = 1;

  function automatic logic [9:0] tx_word(input logic stop, input logic start, input logic [7:0] b);
    logic [9:0] w;
    w            = '0;
    w[7:0]       = b;
    w[TXW_START] = start;
    w[TXW_STOP]  = stop;
    return w;
  endfunction

  // Arbitration loss outranks NACK; anything else reaching here is the watchdog.
  function automatic logic [1:0] err_code(input logic [7:0] irq);
    if (irq[IRQ_AL])        return I2C_ERR_AL;
    else if (irq[IRQ_NACK]) return I2C_ERR_NACK;
    else                    return I2C_ERR_TMO;
  endfunction

endpackage

// File: rtl/i2c_xfer_seq_if.sv
// Request/data/status bundle between the system requester, the sequencer and i2c_core's
// FIFO/status ports. slave = sequencer view, master = requester/core-model view.
interface i2c_xfer_seq_if #(parameter int LEN_W = 4) ();

  logic             req_valid;
  logic             req_ready;
  logic [6:0]       req_addr;
  logic             req_rd;
  logic [LEN_W-1:0] req_len;
  logic             wdata_valid;
  logic [7:0]       wdata;
  logic             wdata_ready;
  logic             rdata_valid;
  logic [7:0]       rdata;
  logic             rdata_ready;
  logic             rsp_valid;
  logic [1:0]       rsp_err;
  logic             tx_fifo_wr;
  logic [9:0]       tx_fifo_din;
  logic             txfifo_rst;
  logic             rx_fifo_rd;
  logic [7:0]       rx_fifo_dout;
  logic [7:0]       sr;
  logic [7:0]       irq_req;

  modport slave (
    input  req_valid, req_addr, req_rd, req_len, wdata_valid, wdata, rdata_ready,
           rx_fifo_dout, sr, irq_req,
    output req_ready, wdata_ready, rdata_valid, rdata, rsp_valid, rsp_err,
           tx_fifo_wr, tx_fifo_din, txfifo_rst, rx_fifo_rd
  );

  modport master (
    output req_valid, req_addr, req_rd, req_len, wdata_valid, wdata, rdata_ready,
           rx_fifo_dout, sr, irq_req,
    input  req_ready, wdata_ready, rdata_valid, rdata, rsp_valid, rsp_err,
           tx_fifo_wr, tx_fifo_din, txfifo_rst, rx_fifo_rd
  );

endinterface

// File: rtl/i2c_xfer_seq.sv
// Transaction sequencer driving i2c_core in TX-FIFO-driven mode, one request at a time.
// Optional watchdog: define I2C_XFER_SEQ_TIMEOUT_EN.
module i2c_xfer_seq
  import i2c_pkg::*;
#(
  parameter int LEN_W      = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int TMO_W      = 20
) (
  input logic           clk,
  input logic           rstn,
  i2c_xfer_seq_if.slave bus
);

  localparam int CNT_W = LEN_W + 1;
  localparam int DRN_W = $clog2(FIFO_DEPTH) + 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DRN_W-1:0] drn_q, drn_d;
  logic [1:0]       err_q, err_d;
  logic             txfifo_rst_q;

  logic [6:0]       addr_q;
  logic             rd_q;
  logic [LEN_W-1:0] len_q;

  logic             tx_full, rx_empty, active, bus_err, last_byte, tmo_hit;

  assign tx_full   = bus.sr[SR_TX_FULL];
  assign rx_empty  = bus.sr[SR_RX_EMPTY];
  assign last_byte = (cnt_q + CNT_W'(1)) == CNT_W'(len_q);
  assign active    = (state_q == S_ADDR) || (state_q == S_WDATA) || (state_q == S_RLEN) ||
                     (state_q == S_RDATA) || (state_q == S_WAIT);
  assign bus_err   = active && (bus.irq_req[IRQ_AL] || bus.irq_req[IRQ_NACK] || tmo_hit);

`ifdef I2C_XFER_SEQ_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q;

  // Any FIFO traffic or the response itself proves progress and restarts the watchdog.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo_q <= '0;
    end else if (state_q == S_IDLE || state_q == S_DONE || bus.tx_fifo_wr || bus.rx_fifo_rd) begin
      tmo_q <= '0;
    end else if (!tmo_hit) begin
      tmo_q <= tmo_q + TMO_W'(1);
    end
  end

  assign tmo_hit = &tmo_q;
`else
  // Watchdog compiled out: constant-false for every legal TMO_W.
  assign tmo_hit = (TMO_W == 0);
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      drn_q        <= '0;
      err_q        <= I2C_ERR_OK;
      txfifo_rst_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      drn_q        <= drn_d;
      err_q        <= err_d;
      txfifo_rst_q <= bus_err;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && bus.req_valid) begin
      addr_q <= bus.req_addr;
      rd_q   <= bus.req_rd;
      len_q  <= bus.req_len;
    end
  end

  assign bus.txfifo_rst = txfifo_rst_q;
  assign bus.rdata      = bus.rx_fifo_dout;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    drn_d           = drn_q;
    err_d           = err_q;
    bus.req_ready   = 1'b0;
    bus.wdata_ready = 1'b0;
    bus.rdata_valid = 1'b0;
    bus.rx_fifo_rd  = 1'b0;
    bus.rsp_valid   = 1'b0;
    bus.rsp_err     = I2C_ERR_OK;
    bus.tx_fifo_wr  = 1'b0;
    bus.tx_fifo_din = '0;

    // An error outranks any push/pop the active state would do this cycle.
    if (bus_err) begin
      state_d = S_ABORT;
      drn_d   = '0;
      err_d   = err_code(bus.irq_req);
    end else begin
      case (state_q)
        S_IDLE: begin
          bus.req_ready = 1'b1;
          if (bus.req_valid) begin
            cnt_d = '0;
            if (bus.req_rd && bus.req_len == '0) begin
              err_d   = I2C_ERR_TMO;
              state_d = S_DONE;
            end else begin
              err_d   = I2C_ERR_OK;
              state_d = S_ADDR;
            end
          end
        end
        S_ADDR: begin
          if (!tx_full) begin
            bus.tx_fifo_wr  = 1'b1;
            bus.tx_fifo_din = tx_word(!rd_q && len_q == '0, 1'b1, {addr_q, rd_q});
            if (rd_q)              state_d = S_RLEN;
            else if (len_q == '0)  state_d = S_WAIT;
            else                   state_d = S_WDATA;
          end
        end
        S_WDATA: begin
          if (!tx_full && bus.wdata_valid) begin
            bus.wdata_ready = 1'b1;
            bus.tx_fifo_wr  = 1'b1;
            bus.tx_fifo_din = tx_word(last_byte, 1'b0, bus.wdata);
            cnt_d           = cnt_q + CNT_W'(1);
            if (last_byte) state_d = S_WAIT;
          end
        end
        S_RLEN: begin
          if (!tx_full) begin
            bus.tx_fifo_wr  = 1'b1;
            bus.tx_fifo_din = tx_word(1'b1, 1'b0, 8'(len_q));
            cnt_d           = '0;
            state_d         = S_RDATA;
          end
        end
        S_RDATA: begin
          bus.rdata_valid = !rx_empty;
          if (!rx_empty && bus.rdata_ready) begin
            bus.rx_fifo_rd = 1'b1;
            cnt_d          = cnt_q + CNT_W'(1);
            if (last_byte) state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.sr[SR_TX_EMPTY] && !bus.sr[SR_BUS_BUSY]) state_d = S_DONE;
        end
        S_DONE: begin
          bus.rsp_valid = 1'b1;
          bus.rsp_err   = err_q;
          state_d       = S_IDLE;
        end
        S_ABORT: begin
          // Drain is bounded by the FIFO depth so a stuck rx_empty cannot hang us.
          if (rx_empty || drn_q == DRN_W'(FIFO_DEPTH)) begin
            state_d = S_DONE;
          end else begin
            bus.rx_fifo_rd = 1'b1;
            drn_d          = drn_q + DRN_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_xfer_seq.sv
// Self-checking bench for i2c_xfer_seq with a small behavioural model of i2c_core's FIFOs/status.
module tb_i2c_xfer_seq;

  localparam int LEN_W = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  i2c_xfer_seq_if #(.LEN_W(LEN_W)) bus ();

  i2c_xfer_seq #(.LEN_W(LEN_W), .FIFO_DEPTH(16), .TMO_W(8)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [9:0] exp_tx[$];
  logic [7:0] exp_rd[$];
  logic [1:0] exp_rsp[$];
  logic [7:0] rx_q[$];
  logic [7:0] wq[$];

  logic tx_full_v = 1'b0;
  logic tx_empty_v = 1'b1;
  logic busy_v = 1'b0;
  int   rx_req = 0, rx_done = 0, w_req = 0, w_done = 0;
  int   rsp_cnt = 0, rst_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Core model: applies pops recorded on the previous cycle and refreshes status just after the edge.
  always @(posedge clk) begin
    #1;
    if (!rstn) begin
      rx_q.delete();
      rx_done = rx_req;
    end
    while (rx_done < rx_req) begin
      if (rx_q.size() > 0) rx_q.delete(0);
      rx_done++;
    end
    while (w_done < w_req) begin
      if (wq.size() > 0) wq.delete(0);
      w_done++;
    end
    bus.sr          = {tx_empty_v, (rx_q.size() == 0), 1'b0, tx_full_v, 1'b0, busy_v, 2'b00};
    bus.rx_fifo_dout = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    bus.wdata_valid = (wq.size() > 0);
    bus.wdata       = (wq.size() > 0) ? wq[0] : 8'h00;
  end

  // Monitor: sampled mid-cycle, compares DUT activity against the scoreboard queues.
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.tx_fifo_wr) begin
        chk("tx_wr_while_full", bus.sr[4], 1'b0);
        chk("tx_exp_avail", exp_tx.size() > 0, 1'b1);
        if (exp_tx.size() > 0) chk("tx_word", bus.tx_fifo_din, exp_tx.pop_front());
      end
      if (bus.rdata_valid && bus.rdata_ready) begin
        chk("rd_pop", bus.rx_fifo_rd, 1'b1);
        chk("rd_exp_avail", exp_rd.size() > 0, 1'b1);
        if (exp_rd.size() > 0) chk("rdata", bus.rdata, exp_rd.pop_front());
      end
      if (bus.rx_fifo_rd) rx_req++;
      if (bus.wdata_ready) begin
        chk("wready_needs_valid", bus.wdata_valid, 1'b1);
        w_req++;
      end
      if (bus.rsp_valid) begin
        rsp_cnt++;
        chk("rsp_exp_avail", exp_rsp.size() > 0, 1'b1);
        if (exp_rsp.size() > 0) chk("rsp_err", bus.rsp_err, exp_rsp.pop_front());
      end
      if (bus.txfifo_rst) rst_cnt++;
    end
  end

  task automatic issue_req(input logic [6:0] a, input logic rd, input logic [LEN_W-1:0] len);
    int k = 0;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_rd    = rd;
    bus.req_len   = len;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.req_ready && k < 100);
    chk("req_accepted", bus.req_ready, 1'b1);
    @(posedge clk);
    #2 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("req_ready_drop", bus.req_ready, 1'b0);
  endtask

  task automatic wait_tx_drained(input int budget);
    int k = 0;
    while (exp_tx.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk("tx_drained", exp_tx.size(), 0);
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int k = 0;
    while (rsp_cnt < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk("rsp_seen", rsp_cnt >= target, 1'b1);
  endtask

  task automatic pulse_irq(input logic [7:0] v);
    @(posedge clk);
    #2 bus.irq_req = v;
    @(posedge clk);
    #2 bus.irq_req = 8'h00;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int r0, c0;
    bus.req_valid   = 1'b0;
    bus.req_addr    = '0;
    bus.req_rd      = 1'b0;
    bus.req_len     = '0;
    bus.rdata_ready = 1'b1;
    bus.irq_req     = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_tx_wr", bus.tx_fifo_wr, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_err", bus.rsp_err, 2'd0);
    chk("rst_txfifo_rst", bus.txfifo_rst, 1'b0);
    chk("rst_wready", bus.wdata_ready, 1'b0);
    chk("rst_rx_rd", bus.rx_fifo_rd, 1'b0);
    chk("rst_rvalid", bus.rdata_valid, 1'b0);
    @(posedge clk);
    #2 rstn = 1'b1;
    @(posedge clk);
    #2;

    // Write 0x50, three bytes; bus held busy so completion waits for the core
    exp_tx.push_back(10'h1A0); exp_tx.push_back(10'h0A1);
    exp_tx.push_back(10'h0A2); exp_tx.push_back(10'h2A3);
    wq.push_back(8'hA1); wq.push_back(8'hA2); wq.push_back(8'hA3);
    exp_rsp.push_back(2'd0);
    busy_v = 1'b1;
    r0 = rsp_cnt;
    issue_req(7'h50, 1'b0, 4'd3);
    wait_tx_drained(100);
    repeat (5) @(posedge clk);
    chk("wait_holds_busy", rsp_cnt, r0);
    busy_v = 1'b0;
    wait_rsp(r0 + 1, 50);
    @(posedge clk); #2;

    // Read 0x50, two bytes
    exp_tx.push_back(10'h1A1); exp_tx.push_back(10'h202);
    rx_q.push_back(8'h5A); rx_q.push_back(8'hC3);
    exp_rd.push_back(8'h5A); exp_rd.push_back(8'hC3);
    exp_rsp.push_back(2'd0);
    r0 = rsp_cnt;
    issue_req(7'h50, 1'b1, 4'd2);
    wait_rsp(r0 + 1, 100);
    chk("rd_all_delivered", exp_rd.size(), 0);
    @(posedge clk); #2;

    // Address probe NACKed
    exp_tx.push_back(10'h3A0);
    exp_rsp.push_back(2'd1);
    busy_v = 1'b1;
    r0 = rsp_cnt;
    c0 = rst_cnt;
    issue_req(7'h50, 1'b0, 4'd0);
    wait_tx_drained(50);
    pulse_irq(8'h02);
    busy_v = 1'b0;
    wait_rsp(r0 + 1, 50);
    chk("nack_txfifo_rst", rst_cnt - c0, 1);
    @(posedge clk); #2;

    // Illegal read of zero bytes
    exp_rsp.push_back(2'd3);
    r0 = rsp_cnt;
    c0 = rst_cnt;
    issue_req(7'h50, 1'b1, 4'd0);
    wait_rsp(r0 + 1, 3);
    chk("illegal_no_txrst", rst_cnt, c0);
    @(posedge clk); #2;

    // Arbitration lost mid-write (NACK raised too: AL must win); late bytes refused
    exp_tx.push_back(10'h1A0); exp_tx.push_back(10'h0B1); exp_tx.push_back(10'h0B2);
    wq.push_back(8'hB1); wq.push_back(8'hB2);
    exp_rsp.push_back(2'd2);
    r0 = rsp_cnt;
    c0 = rst_cnt;
    issue_req(7'h50, 1'b0, 4'd4);
    wait_tx_drained(50);
    #2 wq.push_back(8'hB3); wq.push_back(8'hB4);
    pulse_irq(8'h03);
    wait_rsp(r0 + 1, 50);
    chk("al_wdata_refused", wq.size(), 2);
    chk("al_txfifo_rst", rst_cnt - c0, 1);
    wq.delete();
    @(posedge clk); #2;

    // TX FIFO full for 20 cycles during a write
    exp_tx.push_back(10'h1A0); exp_tx.push_back(10'h0C1);
    exp_tx.push_back(10'h0C2); exp_tx.push_back(10'h2C3);
    wq.push_back(8'hC1); wq.push_back(8'hC2); wq.push_back(8'hC3);
    exp_rsp.push_back(2'd0);
    tx_full_v = 1'b1;
    @(posedge clk); #2;
    r0 = rsp_cnt;
    issue_req(7'h50, 1'b0, 4'd3);
    repeat (20) @(posedge clk);
    chk("full_no_push", exp_tx.size(), 4);
    tx_full_v = 1'b0;
    wait_tx_drained(50);
    wait_rsp(r0 + 1, 50);
    chk("full_no_byte_lost", wq.size(), 0);
    @(posedge clk); #2;

    // Consumer stalls for 50 cycles during a read
    bus.rdata_ready = 1'b0;
    exp_tx.push_back(10'h1A1); exp_tx.push_back(10'h202);
    rx_q.push_back(8'h11); rx_q.push_back(8'h22);
    exp_rd.push_back(8'h11); exp_rd.push_back(8'h22);
    exp_rsp.push_back(2'd0);
    r0 = rsp_cnt;
    issue_req(7'h50, 1'b1, 4'd2);
    repeat (50) @(posedge clk);
    chk("stall_rx_kept", rx_q.size(), 2);
    chk("stall_no_rsp", rsp_cnt, r0);
    #2 bus.rdata_ready = 1'b1;
    wait_rsp(r0 + 1, 50);
    chk("stall_rd_all", exp_rd.size(), 0);
    @(posedge clk); #2;

`ifdef I2C_XFER_SEQ_TIMEOUT_EN
    // Bus stuck busy in WAIT: watchdog (TMO_W=8) fires after 255 idle cycles
    exp_tx.push_back(10'h3A0);
    exp_rsp.push_back(2'd3);
    busy_v = 1'b1;
    r0 = rsp_cnt;
    issue_req(7'h50, 1'b0, 4'd0);
    wait_tx_drained(20);
    repeat (245) @(posedge clk);
    chk("tmo_not_early", rsp_cnt, r0);
    wait_rsp(r0 + 1, 40);
    busy_v = 1'b0;
    @(posedge clk); #2;
`endif

    // Reset mid-read: back to IDLE with no response
    bus.rdata_ready = 1'b0;
    exp_tx.push_back(10'h1A1); exp_tx.push_back(10'h202);
    rx_q.push_back(8'h33); rx_q.push_back(8'h44);
    r0 = rsp_cnt;
    issue_req(7'h50, 1'b1, 4'd2);
    wait_tx_drained(20);
    repeat (5) @(posedge clk);
    #2 rstn = 1'b0;
    @(negedge clk);
    chk("midrst_req_ready", bus.req_ready, 1'b1);
    chk("midrst_rvalid", bus.rdata_valid, 1'b0);
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    bus.rdata_ready = 1'b1;
    repeat (10) @(posedge clk);
    chk("midrst_no_rsp", rsp_cnt, r0);
    @(negedge clk);
    chk("midrst_idle", bus.req_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
